hazard_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RV32 core.
- Detects load-use hazards, sequences multi-cycle MUL/DIV occupancy of EX, and turns EX-resolved redirects (taken branch, jal, jalr) into flushes.
- Drives the stall, bubble, hold and flush controls of the PC, IF/ID and ID/EX registers.
- Keeps free-running stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, multi-cycle MUL/DIV occupancy of EX,
// redirect flushes, plus free-running stall/flush performance counters.
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_load,
    input  logic        ex_md_start,
    input  logic        ex_redirect,
    input  logic        cnt_clr,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_bubble,
    output logic        id_ex_hold,
    output logic        ex_hold,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        md_done,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;
    logic             md_accept;
    logic             redirect_accept;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        load_use = ex_load && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        id_ex_bubble    = 1'b0;
        id_ex_hold      = 1'b0;
        ex_hold         = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        md_done         = 1'b0;
        md_accept       = 1'b0;
        redirect_accept = 1'b0;
        case (state)
            RUN: begin
                if (ex_redirect) begin
                    if_id_flush     = 1'b1;
                    id_ex_flush     = 1'b1;
                    redirect_accept = 1'b1;
                end else if (ex_md_start) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    ex_hold     = 1'b1;
                    md_accept   = 1'b1;
                end else if (load_use) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    ex_hold     = 1'b1;
                end else begin
                    md_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The start cycle counts as one EX cycle and the done cycle as another,
    // so BUSY holds for MD_LAT-2 cycles before the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (md_accept) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(MD_LAT - 2);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_accept) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_load, ex_md_start, ex_redirect, cnt_clr;
    logic        pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, ex_hold;
    logic        if_id_flush, id_ex_flush, md_done;
    logic [31:0] stall_cycles, flush_events;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Model state: EX cycles still owed by the MUL/DIV in flight (0 = free).
    int unsigned md_left = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load),
        .ex_md_start(ex_md_start), .ex_redirect(ex_redirect),
        .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
        .ex_hold(ex_hold), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .md_done(md_done),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Order: pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, ex_hold, if_id_flush, id_ex_flush, md_done
    function automatic logic [7:0] ctrl_vec();
        return {pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, ex_hold,
                if_id_flush, id_ex_flush, md_done};
    endfunction

    function automatic logic [7:0] exp_ctrl();
        bit hazard;
        hazard = ex_load && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (md_left == 0) begin
            if (ex_redirect) return 8'b0000_0110;
            if (ex_md_start) return 8'b1101_1000;
            if (hazard)      return 8'b1110_0000;
            return 8'b0;
        end
        if (md_left > 1) return 8'b1101_1000;
        return 8'b0000_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_load = 0;
        ex_md_start = 0; ex_redirect = 0; cnt_clr = 0;
    endtask

    task automatic model_reset();
        md_left = 0;
        m_stall = '0;
        m_flush = '0;
    endtask

    // Inputs are already applied; check mid-cycle, then advance the model at the edge.
    task automatic step(input string tag);
        logic [7:0] e;
        bit         take_redirect;
        @(negedge clk);
        e = exp_ctrl();
        take_redirect = (md_left == 0) && ex_redirect;
        chk({tag, ".ctrl"}, {24'b0, ctrl_vec()}, {24'b0, e});
        chk({tag, ".stall_cycles"}, stall_cycles, m_stall);
        chk({tag, ".flush_events"}, flush_events, m_flush);
        @(posedge clk);
        if (cnt_clr) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            m_stall = m_stall + {31'b0, e[7]};
            m_flush = m_flush + {31'b0, take_redirect};
        end
        if (md_left == 0) begin
            if (!ex_redirect && ex_md_start) md_left = MD_LAT - 1;
        end else begin
            md_left = md_left - 1;
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #3;
        chk("reset.ctrl", {24'b0, ctrl_vec()}, 32'h0);
        chk("reset.stall_cycles", stall_cycles, 32'h0);
        chk("reset.flush_events", flush_events, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use on rs2
        ex_load = 1; ex_rd = 5'd5; id_use_rs2 = 1; id_rs2 = 5'd5;
        step("loaduse");
        idle();
        step("loaduse_after");
        chk("loaduse.count", stall_cycles, 32'd1);

        // x0 and no-use guards
        ex_load = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1;
        step("x0_guard");
        idle();
        ex_load = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 0;
        step("nouse_guard");
        idle();

        // MUL/DIV occupancy
        ex_md_start = 1;
        step("md_c0");
        idle();
        step("md_c1");
        step("md_c2");
        chk("md_c3.done", {31'b0, md_done}, 32'd0 + 32'(md_left == 1));
        step("md_c3");
        step("md_c4");
        chk("md.count", stall_cycles, 32'd4);

        // Redirect beats a coincident load-use
        ex_redirect = 1; ex_load = 1; ex_rd = 5'd3; id_use_rs1 = 1; id_rs1 = 5'd3;
        step("redirect_lu");
        idle();
        step("redirect_after");
        chk("redirect.count", flush_events, 32'd1);

        // Reset while BUSY
        ex_md_start = 1;
        step("rstbusy_c0");
        idle();
        rst = 1'b1;
        #1;
        chk("rstbusy.ctrl", {24'b0, ctrl_vec()}, 32'h0);
        chk("rstbusy.stall_cycles", stall_cycles, 32'h0);
        chk("rstbusy.flush_events", flush_events, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ex_md_start = 1;
        step("restart_c0");
        idle();
        for (int i = 1; i <= MD_LAT; i++) step($sformatf("restart_c%0d", i));
        chk("restart.count", stall_cycles, 32'd3);

        // Wrap of the stall counter, then clear beating increment
        force dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles;
        m_stall = 32'hFFFF_FFFE;
        ex_load = 1; ex_rd = 5'd9; id_use_rs1 = 1; id_rs1 = 5'd9;
        step("wrap_a");
        step("wrap_b");
        chk("wrap.zero", stall_cycles, 32'h0);
        cnt_clr = 1;
        step("clr_stall");
        idle();
        step("clr_after");
        chk("clr.zero", stall_cycles, 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_load     = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 5) == 0);
            ex_md_start = ($urandom_range(0, 7) == 0);
            cnt_clr     = ($urandom_range(0, 60) == 0);
            step("rand");
        end
        idle();
        step("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
